// File: rtl/mux_ser_pkg.sv
// Shared types and constants for the 16-bit mux serializer.
// Select start/end positions depend on the bit order (MSB_FIRST).
package mux_ser_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StPar
    } state_e;

    localparam logic [SEL_W-1:0] SEL_FIRST_LSB = 4'd0;
    localparam logic [SEL_W-1:0] SEL_LAST_LSB  = 4'd15;
    localparam logic [SEL_W-1:0] SEL_FIRST_MSB = 4'd15;
    localparam logic [SEL_W-1:0] SEL_LAST_MSB  = 4'd0;

    function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
        return msb_first ? SEL_FIRST_MSB : SEL_FIRST_LSB;
    endfunction

    function automatic logic [SEL_W-1:0] sel_last(input bit msb_first);
        return msb_first ? SEL_LAST_MSB : SEL_LAST_LSB;
    endfunction

endpackage

// File: rtl/Mux_16X1.sv
// 16:1 single-bit multiplexer: Y = I[S].
module Mux_16X1 (
    input  logic [15:0] I,
    input  logic [3:0]  S,
    output logic        Y
);

    assign Y = I[S];

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial front-end sweeping the select of a 16:1 mux, one bit per accepted beat.
// Optional trailing even-parity beat when MUX_SER_PARITY_EN is defined.
module mux_serializer
    import mux_ser_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] I,
    output logic [SEL_W-1:0]  S,
    output logic              ser_bit,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic              done
);

    localparam logic [SEL_W-1:0] SelFirst = sel_first(MSB_FIRST);
    localparam logic [SEL_W-1:0] SelLast  = sel_last(MSB_FIRST);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] data_q;
    logic [SEL_W-1:0]  sel_q;
    logic              done_q;
    logic              mux_y;
    logic              beat_acc;
    logic              word_acc;

    assign beat_acc = ser_valid & ser_ready;
    assign word_acc = in_valid & in_ready;

    Mux_16X1 u_mux (
        .I (data_q),
        .S (sel_q),
        .Y (mux_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) state_d = StSend;
            end
            StSend: begin
                if (beat_acc && sel_q == SelLast) begin
`ifdef MUX_SER_PARITY_EN
                    state_d = StPar;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef MUX_SER_PARITY_EN
            StPar: begin
                if (beat_acc) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        ser_valid = (state_q != StIdle);
`ifdef MUX_SER_PARITY_EN
        ser_last  = (state_q == StPar);
        ser_bit   = (state_q == StPar) ? ^data_q : mux_y;
`else
        ser_last  = (state_q == StSend) && (sel_q == SelLast);
        ser_bit   = mux_y;
`endif
    end

    // Select stops at its last value; only the final accepted beat reloads it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= SelFirst;
            done_q <= 1'b0;
        end else begin
            done_q <= beat_acc & ser_last;
            if (word_acc) begin
                data_q <= I;
                sel_q  <= SelFirst;
            end else if (beat_acc && ser_last) begin
                sel_q <= SelFirst;
            end else if (beat_acc && sel_q != SelLast) begin
                sel_q <= MSB_FIRST ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
            end
        end
    end

    assign S    = sel_q;
    assign done = done_q;

endmodule

// File: tb/tb_mux_serializer.sv
// Self-checking bench for mux_serializer: LSB-first and MSB-first instances side by side.
// Expected streams come from table constants or a bit-order/parity reference model.
module tb_mux_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] din       [2];
    logic [3:0]  sel       [2];
    logic        ser_bit   [2];
    logic        ser_valid [2];
    logic        ser_ready [2];
    logic        ser_last  [2];
    logic        done      [2];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MUX_SER_PARITY_EN
    localparam int NBEATS = 17;
`else
    localparam int NBEATS = 16;
`endif

    always #5 clk = ~clk;

    mux_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .I         (din[0]),
        .S         (sel[0]),
        .ser_bit   (ser_bit[0]),
        .ser_valid (ser_valid[0]),
        .ser_ready (ser_ready[0]),
        .ser_last  (ser_last[0]),
        .done      (done[0])
    );

    mux_serializer #(.MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .I         (din[1]),
        .S         (sel[1]),
        .ser_bit   (ser_bit[1]),
        .ser_valid (ser_valid[1]),
        .ser_ready (ser_ready[1]),
        .ser_last  (ser_last[1]),
        .done      (done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the bit index carried by beat k, and the stream order in time.
    function automatic logic [3:0] beat_sel(input int u, input int k);
        int idx;
        if (k >= 16) idx = (u == 1) ? 0 : 15;
        else         idx = (u == 1) ? 15 - k : k;
        return 4'(idx);
    endfunction

    function automatic logic [15:0] model_seq(input int u, input logic [15:0] w);
        logic [15:0] s;
        for (int k = 0; k < 16; k++) s[k] = w[beat_sel(u, k)];
        return s;
    endfunction

    function automatic logic model_par(input logic [15:0] w);
        return 1'($countones(w) % 2);
    endfunction

    // Called at a negedge. Ends at the negedge of the done cycle.
    // preloaded: in_valid/din already set and in_ready high, so the handshake is the next edge.
    task automatic run_word(input int u, input logic [15:0] w, input logic [15:0] exp_seq,
                            input logic exp_par, input int mode, input bit preloaded,
                            input bit keep_valid, input logic [15:0] next_w);
        int k;
        int cyc;
        int waits;
        logic exp_bit;
        if (!preloaded) begin
            waits = 0;
            while (!in_ready[u] && waits < 50) begin
                @(negedge clk);
                waits++;
            end
            check("in_ready_before_word", 32'(in_ready[u]), 32'd1);
            din[u]      = w;
            in_valid[u] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[u] = keep_valid;
        if (keep_valid) din[u] = next_w;
        k   = 0;
        cyc = 0;
        while (k < NBEATS && cyc < 200) begin
            case (mode)
                0:       ser_ready[u] = 1'b1;
                1:       ser_ready[u] = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: ser_ready[u] = 1'($urandom_range(0, 1));
            endcase
            exp_bit = (k < 16) ? exp_seq[k] : exp_par;
            check("beat_valid", 32'(ser_valid[u]), 32'd1);
            check("beat_sel",   32'(sel[u]), 32'(beat_sel(u, k)));
            check("beat_bit",   32'(ser_bit[u]), 32'(exp_bit));
            check("beat_last",  32'(ser_last[u]), 32'(k == NBEATS - 1));
            check("busy_ready", 32'(in_ready[u]), 32'd0);
            check("busy_done",  32'(done[u]), 32'd0);
            if (ser_valid[u] && ser_ready[u]) k++;
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        check("beats_before_timeout", 32'(k), 32'(NBEATS));
        check("done_pulse",     32'(done[u]), 32'd1);
        check("done_in_ready",  32'(in_ready[u]), 32'd1);
        check("done_valid_low", 32'(ser_valid[u]), 32'd0);
        check("done_last_low",  32'(ser_last[u]), 32'd0);
        check("done_sel_start", 32'(sel[u]), 32'(beat_sel(u, 0)));
    endtask

    typedef struct {
        int          unit;
        int          mode;
        logic [15:0] word;
        logic [15:0] exp_seq;
        logic        exp_par;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          u;

        vecs[0] = '{unit: 0, mode: 0, word: 16'h56D5, exp_seq: 16'h56D5, exp_par: 1'b1};
        vecs[1] = '{unit: 1, mode: 0, word: 16'h56D5, exp_seq: 16'hAB6A, exp_par: 1'b1};
        vecs[2] = '{unit: 0, mode: 1, word: 16'h56D5, exp_seq: 16'h56D5, exp_par: 1'b1};
        vecs[3] = '{unit: 0, mode: 0, word: 16'h0000, exp_seq: 16'h0000, exp_par: 1'b0};
        vecs[4] = '{unit: 1, mode: 1, word: 16'hFFFF, exp_seq: 16'hFFFF, exp_par: 1'b0};
        vecs[5] = '{unit: 1, mode: 0, word: 16'h0001, exp_seq: 16'h8000, exp_par: 1'b1};
        vecs[6] = '{unit: 0, mode: 2, word: 16'h8421, exp_seq: 16'h8421, exp_par: 1'b0};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            din[i]       = 16'h0;
            ser_ready[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready",  32'(in_ready[i]), 32'd1);
            check("rst_ser_valid", 32'(ser_valid[i]), 32'd0);
            check("rst_ser_last",  32'(ser_last[i]), 32'd0);
            check("rst_done",      32'(done[i]), 32'd0);
            check("rst_sel",       32'(sel[i]), 32'(beat_sel(i, 0)));
            check("rst_ser_bit",   32'(ser_bit[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_word(vecs[i].unit, vecs[i].word, vecs[i].exp_seq, vecs[i].exp_par,
                     vecs[i].mode, 1'b0, 1'b0, 16'h0);
            @(negedge clk);
            check("done_single_pulse", 32'(done[vecs[i].unit]), 32'd0);
        end

        // Second word held on in_valid while busy: taken in the done cycle, one bubble.
        w = 16'hBEEF;
        run_word(0, 16'h1234, model_seq(0, 16'h1234), model_par(16'h1234), 0, 1'b0, 1'b1, w);
        check("b2b_valid_held", 32'(in_valid[0]), 32'd1);
        run_word(0, w, model_seq(0, w), model_par(w), 0, 1'b1, 1'b0, 16'h0);
        @(negedge clk);

        // Reset in the middle of a word.
        din[0]       = 16'h56D5;
        in_valid[0]  = 1'b1;
        ser_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_word_sel", 32'(sel[0]), 32'd7);
        check("mid_word_bit", 32'(ser_bit[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid",    32'(ser_valid[0]), 32'd0);
        check("abort_in_ready", 32'(in_ready[0]), 32'd1);
        check("abort_sel",      32'(sel[0]), 32'd0);
        check("abort_done",     32'(done[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", 32'(done[0]), 32'd0);
        check("abort_idle",    32'(ser_valid[0]), 32'd0);

        // Reset and handshake on the same edge: reset wins, word not captured.
        rst_n       = 1'b0;
        din[0]      = 16'hFFFF;
        in_valid[0] = 1'b1;
        @(negedge clk);
        check("rst_hs_valid", 32'(ser_valid[0]), 32'd0);
        rst_n       = 1'b1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("rst_hs_idle", 32'(ser_valid[0]), 32'd0);
        check("rst_hs_data", 32'(ser_bit[0]), 32'd0);
        run_word(0, 16'h56D5, 16'h56D5, 1'b1, 0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);

        // Randomized words against the reference model.
        for (int i = 0; i < 16; i++) begin
            w = 16'($urandom);
            u = int'($urandom_range(0, 1));
            run_word(u, w, model_seq(u, w), model_par(w), (i % 2 == 0) ? 0 : 2,
                     1'b0, 1'b0, 16'h0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
